// File: rtl/fetch_pkg.sv
// fetch_pkg: shared opcodes, instruction field positions and FSM states for the fetch stage
// No ports; imported by fetch_unit and fetch_hazard_detector.
package fetch_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b010010;
  localparam logic [5:0] OP_LW = 6'b010011;
  localparam logic [5:0] OP_SW = 6'b010100;
  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
endpackage

// File: rtl/fetch_hazard_detector.sv
// fetch_hazard_detector: two-slot destination history and RAW compare for the pending word
// Ports: clk, rst_n (sync active-low); clr_i clears history; shift_i advances history one slot;
//        word_i opcode..rd fields of the pending word; hazard_o pending word reads a recent dest.
import fetch_pkg::*;

module fetch_hazard_detector (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [OP_HI:RD_LO] word_i,
  output logic               hazard_o
);
  logic [4:0] d0_q, d1_q, rs, rt, rd, dst;
  logic v0_q, v1_q, is_r, is_lw, is_sw, hit_rs, hit_rt, dst_vld;
  always_comb begin
    is_r = word_i[OP_HI:OP_LO] == OP_RTYPE;
    is_lw = word_i[OP_HI:OP_LO] == OP_LW;
    is_sw = word_i[OP_HI:OP_LO] == OP_SW;
    rs = word_i[RS_HI:RS_LO];
    rt = word_i[RT_HI:RT_LO];
    rd = word_i[RD_HI:RD_LO];
    hit_rs = (v0_q && d0_q == rs) || (v1_q && d1_q == rs);
    hit_rt = (v0_q && d0_q == rt) || (v1_q && d1_q == rt);
    hazard_o = ((is_r || is_lw || is_sw) && hit_rs) || ((is_r || is_sw) && hit_rt);
    // a bubble slot carries no destination, so it shifts in an invalid entry
    dst_vld = !hazard_o && (is_r || is_lw);
    dst = is_r ? rd : rt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else if (shift_i) begin
      v1_q <= v0_q;
      d1_q <= d0_q;
      v0_q <= dst_vld;
      d0_q <= dst;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and registered instruction issue over a 1-cycle-latency imem
// Ports: clk, rst_n (sync active-low), start, stall, imem_addr/imem_q (instruction memory),
//        instr/instr_valid/pc_out/bubble (issued slot to decode), done (program fully issued).
// Build option: HAZARD_INTERLOCK_EN compiles in RAW bubble insertion.
import fetch_pkg::*;

module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LAST_ADDR = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  bubble,
  output logic                  done
);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, pco_q, pco_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d, bub_q, bub_d, done_q, done_d, hazard;
`ifdef HAZARD_INTERLOCK_EN
  fetch_hazard_detector u_haz (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != RUN),
    .shift_i  (state_q == RUN && !stall),
    .word_i   (imem_q[OP_HI:RD_LO]),
    .hazard_o (hazard)
  );
`else
  assign hazard = 1'b0;
`endif
  assign instr = instr_q;
  assign instr_valid = valid_q;
  assign pc_out = pco_q;
  assign bubble = bub_q;
  assign done = done_q;
  // pend_q is the address whose word is on imem_q; pc_q is the next address to fetch
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pco_d = pco_q;
    bub_d = bub_q;
    done_d = done_q;
    imem_addr = '0;
    case (state_q)
      IDLE: state_d = start ? FILL : IDLE;
      FILL: begin
        imem_addr = pc_q;
        pend_d = pc_q;
        pc_d = pc_q + ADDR_WIDTH'(1);
        state_d = RUN;
      end
      RUN: begin
        // on stall or bubble, re-read the pending word so it is still on imem_q next cycle
        imem_addr = (stall || hazard) ? pend_q : pc_q;
        if (!stall) begin
          valid_d = 1'b1;
          pco_d = pend_q;
          bub_d = hazard;
          instr_d = hazard ? DATA_WIDTH'(NOP_WORD) : imem_q;
          if (!hazard && pend_q == ADDR_WIDTH'(LAST_ADDR)) state_d = DONE;
          else if (!hazard) begin
            pend_d = pc_q;
            pc_d = pc_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        bub_d = 1'b0;
        done_d = !start;
        if (start) begin
          state_d = FILL;
          pc_d = '0;
          pend_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      pend_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      pco_q <= '0;
      bub_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pco_q <= pco_d;
      bub_q <= bub_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stall/start stimulus checked against a slot-list reference model
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LAST = 7;
  localparam logic [5:0] T_R = 6'b010010, T_LW = 6'b010011, T_SW = 6'b010100;
  logic clk = 0, rst_n = 0, start = 0, stall = 0;
  logic [AW-1:0] imem_addr, pc_out;
  logic [DW-1:0] imem_q, instr;
  logic instr_valid, bubble, done;
  logic [DW-1:0] mem [1<<AW];
  typedef struct {int pc; logic [31:0] w; bit b;} slot_t;
  slot_t slots[$];
  int ph = 0, idx = -1, m_pc = 0, tests = 0, fails = 0, n_valid, n_bub;
  bit m_valid = 0, m_done = 0, m_bub = 0, armed = 0;
  logic [31:0] m_instr = 0;

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LAST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .imem_addr(imem_addr),
    .imem_q(imem_q), .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out),
    .bubble(bubble), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_q <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'h0};
  endfunction

  function automatic int dest(logic [31:0] w);
    if (w[31:26] == T_R) return int'(w[15:11]);
    if (w[31:26] == T_LW) return int'(w[20:16]);
    return -1;
  endfunction

  function automatic bit raw(logic [31:0] w, int h0, int h1);
    logic [5:0] op = w[31:26];
    int rs = int'(w[25:21]), rt = int'(w[20:16]);
    bit urs = op == T_R || op == T_LW || op == T_SW;
    bit urt = op == T_R || op == T_SW;
    return (urs && (rs == h0 || rs == h1)) || (urt && (rt == h0 || rt == h1));
  endfunction

  // expected issue stream of the program, independent of stall timing
  task automatic build();
    int h0 = -1, h1 = -1;
    slots.delete();
    for (int a = 0; a <= LAST; a++) begin
`ifdef HAZARD_INTERLOCK_EN
      while (raw(mem[a], h0, h1)) begin
        slots.push_back('{pc: a, w: 32'h0, b: 1'b1});
        h1 = h0;
        h0 = -1;
      end
`endif
      slots.push_back('{pc: a, w: mem[a], b: 1'b0});
      h1 = h0;
      h0 = dest(mem[a]);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit st);
    if (!r) begin
      ph = 0; idx = -1; m_valid = 0; m_done = 0; m_bub = 0; m_instr = 0; m_pc = 0;
    end else case (ph)
      0: if (s) ph = 1;
      1: ph = 2;
      2: if (!st) begin
        idx++;
        m_valid = 1; m_instr = slots[idx].w; m_pc = slots[idx].pc; m_bub = slots[idx].b;
        if (idx == slots.size() - 1) ph = 3;
      end
      default: begin
        m_valid = 0; m_bub = 0; m_done = !s;
        if (s) begin ph = 1; idx = -1; end
      end
    endcase
  endtask

  function automatic logic [AW-1:0] exp_addr(bit st);
    if (ph != 2) return '0;
    return (st || slots[idx+1].b) ? AW'(slots[idx+1].pc) : AW'(slots[idx+1].pc + 1);
  endfunction

  task automatic step(input bit r, input bit s, input bit st);
    rst_n = r; start = s; stall = st;
    #1;
    if (armed) chk("imem_addr", 32'(imem_addr), 32'(exp_addr(st)));
    @(posedge clk);
    model(r, s, st);
    armed = 1;
    #1;
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("done", 32'(done), 32'(m_done));
    chk("bubble", 32'(bubble), 32'(m_bub));
    chk("instr", instr, m_instr);
    chk("pc_out", 32'(pc_out), 32'(m_pc));
    n_valid += int'(instr_valid);
    n_bub += int'(bubble);
  endtask

  task automatic go(input int pct, input bit rs);
    for (int i = 0; i < 300 && ph != 3; i++)
      step(1, rs && ph == 2 && $urandom_range(0, 7) == 0, $urandom_range(0, 99) < pct);
    repeat (3) step(1, 0, 0);
  endtask

  task automatic wait_pc(input int a);
    for (int i = 0; i < 100 && !(m_valid && m_pc == a); i++) step(1, 0, 0);
    chk("reach_pc", 32'(pc_out), 32'(a));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int k = 0; k < 4; k++) mem[k] = enc(T_LW, 0, k + 1, 0);
    mem[4] = enc(T_R, 1, 2, 5);
    mem[5] = enc(T_R, 4, 1, 6);
    mem[6] = enc(T_R, 6, 1, 7);
    mem[7] = enc(T_SW, 0, 7, 0);
    build();
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    n_valid = 0; n_bub = 0;
    step(1, 1, 0);
    go(0, 0);
`ifdef HAZARD_INTERLOCK_EN
    chk("slot_count", 32'(n_valid), 32'd13);
    chk("bubble_count", 32'(n_bub), 32'd5);
`else
    chk("slot_count", 32'(n_valid), 32'd8);
    chk("bubble_count", 32'(n_bub), 32'd0);
`endif
    step(1, 1, 0);
    wait_pc(4);
    repeat (3) step(1, 0, 1);
    go(0, 0);
    step(1, 1, 0);
    wait_pc(3);
    step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    step(1, 1, 0);
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    go(0, 0);
    step(1, 1, 0);
    go(0, 0);
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a <= LAST; a++) begin
        logic [5:0] op;
        case ($urandom_range(0, 3))
          0: op = T_R;
          1: op = T_LW;
          2: op = T_SW;
          default: op = 6'(($urandom_range(0, 15)) << 2);
        endcase
        mem[a] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
                 | 32'($urandom_range(0, 2047));
      end
      build();
      step(1, 1, $urandom_range(0, 1) == 1);
      go(30, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the pipelined MIPS-style core: generates the program counter and drives the synchronous-read instruction memory's address port. It absorbs the memory's one-cycle read latency and presents one registered instruction per cycle to decode, with downstream stall and end-of-program halt. An optional RAW-hazard interlock inserts NOP bubbles in hardware, so programs do not need software bubbles.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 10, instruction memory address width
- LAST_ADDR, 20, address of final instruction; fetch halts after issuing it
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin fetch from address 0; honoured in IDLE and DONE only
- stall  in  1  decode cannot accept; hold current output
- imem_addr  out  ADDR_WIDTH  address to instruction memory
- imem_q  in  DATA_WIDTH  instruction memory read data (valid one cycle after address)
- instr  out  DATA_WIDTH  registered instruction to decode
- instr_valid  out  1  instr holds an issued slot
- pc_out  out  ADDR_WIDTH  address of instr (address of the replayed instruction when bubble=1)
- bubble  out  1  instr is a hardware-inserted NOP
- done  out  1  program fully issued; sticky until start or reset

## Operation
- States: IDLE, FILL, RUN, DONE.
- Reset: state=IDLE, pc=0, pc_q=0, instr=0, instr_valid=0, pc_out=0, bubble=0, done=0, hazard history cleared. imem_addr=0.
- IDLE: imem_addr=0. start -> FILL.
- FILL: imem_addr=pc (0); at the edge, pc<=1, pc_q<=0 -> RUN. stall is ignored.
- RUN, stall=1: instr, instr_valid, pc_out, bubble, pc, pc_q and history hold. imem_addr=pc_q, so the memory re-reads the pending word.
- RUN, stall=0, hazard: instr<=0 (NOP), instr_valid<=1, bubble<=1, pc_out<=pc_q. pc and pc_q hold; imem_addr=pc_q; history shifts in an invalid entry.
- RUN, stall=0, no hazard: instr<=imem_q, instr_valid<=1, bubble<=0, pc_out<=pc_q, pc_q<=pc, pc<=pc+1 (wraps modulo 2^ADDR_WIDTH). If pc_q==LAST_ADDR -> DONE instead of advancing.
- Otherwise in RUN: imem_addr=pc.
- DONE: at the entry edge instr_valid<=0, done<=1. imem_addr=0. start -> FILL, with done<=0 and pc/history reset.
- start in FILL/RUN is ignored. Reset mid-run aborts immediately to reset values.
- Stall priority: stall > hazard > issue.

## Timing
- start sampled at edge E0; first instruction (address 0) is on instr with instr_valid=1 after E2. Latency is 2 cycles.
- Sustained throughput: 1 instruction/cycle with no stall or hazard.
- Address LAST_ADDR issued at edge En; at En+1 instr_valid=0 and done=1.
- A stall during the cycle of the final instruction delays DONE by one cycle per stall cycle.

## Configuration
- HAZARD_INTERLOCK_EN defined: hazard detection is compiled in.
  - Decode the word on imem_q. Sources: R-type (opcode 010010) rs and rt; lw (010011) rs; sw (010100) rs and rt.
  - History holds dest registers of the previous 2 issued slots, each with a valid bit. R-type dest is rd; lw dest is rt; sw, NOP and bubbles have no dest.
  - Hazard = any source equals a valid history dest.
- HAZARD_INTERLOCK_EN undefined: hazard is tied 0, bubble is tied 0, no history registers exist, and the stream passes through unmodified.

## Structure
- fetch_pkg: opcode constants OP_RTYPE=6'b010010, OP_LW=6'b010011, OP_SW=6'b010100; NOP_WORD=32'h0; state enum; field bit-range constants (opcode 31:26, rs 25:21, rt 20:16, rd 15:11).
- One sub-module, fetch_hazard_detector (history shift register plus compare), instantiated only under HAZARD_INTERLOCK_EN.

## Test plan
- Macro off, program at 0..7 (4 lw, MUL, ADD, SUB, sw), LAST_ADDR=7, start pulse -> instr_valid high for exactly 8 consecutive cycles from E2, pc_out 0..7, instr equals memory words, then done=1.
- Macro off, stall held 3 cycles while pc_out=4 -> instr and pc_out hold 4 for 4 cycles total, then pc_out=5 with the correct word and no skipped or duplicated address.
- Macro on, same program -> 13 valid slots. bubble=1 once before ADD (addr 5), twice before SUB (addr 6), and twice before sw (addr 7). Non-bubble pc_out sequence is 0..7.
- Reset asserted while pc_out=3 -> the next cycle shows all outputs at reset values and state IDLE. A later start restarts at address 0.
- start asserted during RUN -> ignored. start in DONE -> done clears on the following edge and the first instruction reappears 2 cycles later.
- Simultaneous stall and hazard -> output holds (no bubble inserted); the bubble appears on the first cycle after stall deasserts.
